// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage M-extension unit: funct3 operation
// encoding, FSM state encoding, the default operand width and small helpers
// that classify an operation's signedness.
// ----------------------------------------------------------------------------
package muldiv_pkg;

  // Default operand width; also the iteration count of the serial engines.
  localparam int MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  // rs1 is treated as two's complement for these operations.
  function automatic logic op_signed_rs1(input logic [2:0] f3);
    logic s;
    case (f3)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                                    s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is treated as two's complement for these operations.
  function automatic logic op_signed_rs2(input logic [2:0] f3);
    logic s;
    case (f3)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-divide iteration. The partial remainder is
// shifted left with the next dividend bit; if the divisor fits, it is
// subtracted and the quotient bit is 1, otherwise the shifted value is kept.
//
// Ports:
//   rem_in       partial remainder before this step (always < divisor)
//   dividend_bit next dividend bit, MSB first
//   divisor      divisor magnitude
//   rem_out      partial remainder after this step
//   q_bit        quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step #(
  parameter int size = 32
) (
  input  logic [size-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [size-1:0] divisor,
  output logic [size-1:0] rem_out,
  output logic            q_bit
);

  logic [size:0] shifted_s;
  logic [size:0] diff_s;

  // Trial subtraction; since rem_in < divisor the difference always fits in
  // size bits when non-negative, so its top bit is a clean borrow flag.
  always_comb begin
    shifted_s = {rem_in, dividend_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    if (!diff_s[size]) begin
      rem_out = diff_s[size-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[size-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// EX-stage M-extension unit: iterative shift-add multiplier and restoring
// divider sharing one 2*size accumulator, controlled by an IDLE/MUL/DIV/DONE
// FSM. Operands are converted to magnitudes at accept and the sign is applied
// when the result is written.
//
// Optional build macro MULDIV_FAST_MUL_EN: multiply ops use a single-cycle
// combinational product and go straight from IDLE to DONE.
//
// Ports:
//   CLK, RESET_N     clock (rising edge), asynchronous active-low reset
//   start_EX         EX instruction is an M op (held while stall is high)
//   funct3_EX        operation select
//   read_data1_EX    rs1 operand
//   read_data2_EX    rs2 operand
//   wrin_EX          destination register index
//   flush            abort whatever is in flight
//   stall            freeze PC, IF/ID and ID/EX
//   busy             FSM is in MUL or DIV
//   result           last result, valid while result_valid is high
//   result_valid     one-cycle completion pulse
//   wrin_out         destination index of the completed op
// ----------------------------------------------------------------------------
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int size = MULDIV_ITER
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            start_EX,
  input  logic [2:0]      funct3_EX,
  input  logic [size-1:0] read_data1_EX,
  input  logic [size-1:0] read_data2_EX,
  input  logic [4:0]      wrin_EX,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [size-1:0] result,
  output logic            result_valid,
  output logic [4:0]      wrin_out
);

  localparam int              CNT_W    = $clog2(size) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [size-1:0] MIN_NEG  = {1'b1, {(size-1){1'b0}}};
  localparam logic [size-1:0] ALL_ONES = {size{1'b1}};
  localparam logic [size-1:0] ZEROS    = {size{1'b0}};

  // Two's complement negate when neg is set (single and double width).
  function automatic logic [size-1:0] neg_if(input logic neg, input logic [size-1:0] v);
    logic [size-1:0] r;
    if (neg) r = ~v + {{(size-1){1'b0}}, 1'b1};
    else     r = v;
    return r;
  endfunction

  function automatic logic [2*size-1:0] neg2_if(input logic neg, input logic [2*size-1:0] v);
    logic [2*size-1:0] r;
    if (neg) r = ~v + {{(2*size-1){1'b0}}, 1'b1};
    else     r = v;
    return r;
  endfunction

  // FSM and control
  muldiv_state_e    state_r, state_nx_s;
  logic             accept_s;
  logic             last_iter_s;
  logic             stall_s, busy_nx_s, valid_nx_s;

  // Accept-time operand decode
  logic             neg_a_s, neg_b_s;
  logic [size-1:0]  abs_a_s, abs_b_s;
  logic             div_zero_s, div_ovf_s, special_s;

  // Datapath state: acc_r is {hi, lo}; for multiply lo holds the multiplier
  // being shifted out, for divide hi is the remainder and lo the dividend /
  // quotient shift register.
  logic [CNT_W-1:0]  cnt_r;
  logic [2*size-1:0] acc_r;
  logic [size-1:0]   opb_r;
  logic [2:0]        op_r;
  logic [4:0]        wrin_r;
  logic              neg_q_r, neg_r_r;

  // Iteration and result logic
  logic [size:0]     mul_sum_s;
  logic [2*size-1:0] mul_acc_nx_s;
  logic [2*size-1:0] div_acc_nx_s;
  logic [size-1:0]   div_rem_s;
  logic              div_qbit_s;
  logic [2*size-1:0] mul_full_s;
  logic [2*size-1:0] fast_full_s;
  logic [size-1:0]   quo_s, rem_s;
  logic [size-1:0]   final_s;

  // Output registers
  logic              busy_r, result_valid_r;
  logic [size-1:0]   result_r;
  logic [4:0]        wrin_out_r;

  assign accept_s    = (state_r == ST_IDLE) & start_EX & ~flush;
  assign last_iter_s = (cnt_r == CNT_ONE);

  // Operand magnitudes, signs and divide special cases seen at accept.
  always_comb begin
    neg_a_s    = op_signed_rs1(funct3_EX) & read_data1_EX[size-1];
    neg_b_s    = op_signed_rs2(funct3_EX) & read_data2_EX[size-1];
    abs_a_s    = neg_if(neg_a_s, read_data1_EX);
    abs_b_s    = neg_if(neg_b_s, read_data2_EX);
    div_zero_s = (read_data2_EX == ZEROS);
    // Only DIV/REM (signed divides: funct3[0]=0) can overflow.
    div_ovf_s  = ~funct3_EX[0] & (read_data1_EX == MIN_NEG) & (read_data2_EX == ALL_ONES);
    special_s  = funct3_EX[2] & (div_zero_s | div_ovf_s);
  end

  // One shift-add multiply step and one restoring divide step on acc_r.
  always_comb begin
    mul_sum_s    = {1'b0, acc_r[2*size-1:size]} +
                   (acc_r[0] ? {1'b0, opb_r} : {(size+1){1'b0}});
    mul_acc_nx_s = {mul_sum_s, acc_r[size-1:1]};
    div_acc_nx_s = {div_rem_s, acc_r[size-2:0], div_qbit_s};
  end

  div_step #(.size(size)) u_div_step (
    .rem_in       (acc_r[2*size-1:size]),
    .dividend_bit (acc_r[size-1]),
    .divisor      (opb_r),
    .rem_out      (div_rem_s),
    .q_bit        (div_qbit_s)
  );

  // Value written to result on entry to DONE; built from the final iteration
  // so it is ready on the same edge that enters DONE.
  always_comb begin
    mul_full_s  = neg2_if(neg_q_r, mul_acc_nx_s);
    quo_s       = neg_if(neg_q_r, div_acc_nx_s[size-1:0]);
    rem_s       = neg_if(neg_r_r, div_acc_nx_s[2*size-1:size]);
`ifdef MULDIV_FAST_MUL_EN
    fast_full_s = neg2_if(neg_a_s ^ neg_b_s,
                          {{size{1'b0}}, abs_a_s} * {{size{1'b0}}, abs_b_s});
`else
    fast_full_s = {(2*size){1'b0}};
`endif
    case (state_r)
      ST_IDLE: begin
        if (funct3_EX[2]) begin
          // Divide shortcuts: funct3[1] selects remainder.
          if (div_zero_s) final_s = funct3_EX[1] ? read_data1_EX : ALL_ONES;
          else            final_s = funct3_EX[1] ? ZEROS : read_data1_EX;
        end else if (funct3_EX == OP_MUL) begin
          final_s = fast_full_s[size-1:0];
        end else begin
          final_s = fast_full_s[2*size-1:size];
        end
      end
      ST_MUL: begin
        if (op_r == OP_MUL) final_s = mul_full_s[size-1:0];
        else                final_s = mul_full_s[2*size-1:size];
      end
      ST_DIV: begin
        if (op_r[1]) final_s = rem_s;
        else         final_s = quo_s;
      end
      default: final_s = result_r;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_r <= ST_IDLE;
    else          state_r <= state_nx_s;
  end

  // FSM next-state logic; flush overrides everything.
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!start_EX) begin
            state_nx_s = ST_IDLE;
          end else if (!funct3_EX[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            state_nx_s = ST_DONE;
`else
            state_nx_s = ST_MUL;
`endif
          end else if (special_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_DIV;
          end
        end
        ST_MUL:  state_nx_s = last_iter_s ? ST_DONE : ST_MUL;
        ST_DIV:  state_nx_s = last_iter_s ? ST_DONE : ST_DIV;
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stall is combinational so the accept cycle already stalls.
  always_comb begin
    stall_s    = accept_s | (state_r == ST_MUL) | (state_r == ST_DIV);
    busy_nx_s  = (state_nx_s == ST_MUL) | (state_nx_s == ST_DIV);
    valid_nx_s = (state_nx_s == ST_DONE);
  end

  // Operand capture at accept and one iteration per cycle in MUL/DIV.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*size){1'b0}};
      opb_r   <= {size{1'b0}};
      op_r    <= 3'b000;
      wrin_r  <= 5'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= CNT_W'(size);
      acc_r   <= {{size{1'b0}}, abs_a_s};
      opb_r   <= abs_b_s;
      op_r    <= funct3_EX;
      wrin_r  <= wrin_EX;
      neg_q_r <= neg_a_s ^ neg_b_s;
      neg_r_r <= neg_a_s;
    end else if (state_r == ST_MUL) begin
      acc_r   <= mul_acc_nx_s;
      cnt_r   <= cnt_r - CNT_ONE;
    end else if (state_r == ST_DIV) begin
      acc_r   <= div_acc_nx_s;
      cnt_r   <= cnt_r - CNT_ONE;
    end
  end

  // Registered outputs; result/wrin_out change only on entry to DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_r       <= {size{1'b0}};
      wrin_out_r     <= 5'd0;
    end else begin
      busy_r         <= busy_nx_s;
      result_valid_r <= valid_nx_s;
      if (valid_nx_s) begin
        result_r   <= final_s;
        wrin_out_r <= accept_s ? wrin_EX : wrin_r;
      end
    end
  end

  assign stall        = stall_s;
  assign busy         = busy_r;
  assign result       = result_r;
  // A flush arriving in the DONE cycle suppresses the completion pulse.
  assign result_valid = result_valid_r & ~flush;
  assign wrin_out     = wrin_out_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
// Directed self-checking bench for ex_muldiv (size = 32) with hand-computed
// expected results, latencies, stall counts, flush and mid-op reset.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          start_EX;
  logic [2:0]    funct3_EX;
  logic [W-1:0]  read_data1_EX;
  logic [W-1:0]  read_data2_EX;
  logic [4:0]    wrin_EX;
  logic          flush;
  logic          stall;
  logic          busy;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [4:0]    wrin_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ex_muldiv #(.size(W)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .start_EX      (start_EX),
    .funct3_EX     (funct3_EX),
    .read_data1_EX (read_data1_EX),
    .read_data2_EX (read_data2_EX),
    .wrin_EX       (wrin_EX),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .result        (result),
    .result_valid  (result_valid),
    .wrin_out      (wrin_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next rising edge and follow it to completion.
  // keep=1 leaves start_EX high so a following call is accepted back-to-back.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr, input logic [31:0] exp_res,
                        input int exp_lat, input bit keep, output int acc_cyc);
    int stall_cnt;
    int lat_obs;
    logic busy1;
    logic [31:0] res_obs;
    logic [4:0] wr_obs;
    @(posedge CLK); #1;
    start_EX = 1'b1; funct3_EX = f3; read_data1_EX = a; read_data2_EX = b; wrin_EX = wr;
    acc_cyc = cyc;
    @(negedge CLK);
    stall_cnt = stall ? 1 : 0;
    lat_obs = 0; busy1 = 1'b0; res_obs = 32'h0; wr_obs = 5'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 1) busy1 = busy;
      if (stall) stall_cnt++;
      if (result_valid) begin
        lat_obs = c; res_obs = result; wr_obs = wrin_out;
        break;
      end
    end
    check_val({tag, ".result"}, res_obs, exp_res);
    check_val({tag, ".wrin"}, {27'd0, wr_obs}, {27'd0, wr});
    check_val({tag, ".latency"}, lat_obs, exp_lat);
    check_val({tag, ".stall_cycles"}, stall_cnt, exp_lat);
    check_val({tag, ".busy_c1"}, {31'd0, busy1}, (exp_lat > 1) ? 32'd1 : 32'd0);
    if (!keep) begin
      @(posedge CLK); #1;
      start_EX = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    int pulses;
    RESET_N = 1'b0; start_EX = 1'b0; funct3_EX = 3'b000;
    read_data1_EX = 32'h0; read_data2_EX = 32'h0; wrin_EX = 5'd0; flush = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check_val("rst.stall", {31'd0, stall}, 32'd0);
    check_val("rst.busy", {31'd0, busy}, 32'd0);
    check_val("rst.valid", {31'd0, result_valid}, 32'd0);
    check_val("rst.result", result, 32'h0);
    check_val("rst.wrin_out", {27'd0, wrin_out}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Multiply family
    run_op("mul_7_m3",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT, 1'b0, a0);
    run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, MUL_LAT, 1'b0, a0);
    run_op("mulh_m1_m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000000, MUL_LAT, 1'b0, a0);
    run_op("mulh_m3_5",   3'b001, 32'hFFFFFFFD, 32'd5,        5'd10, 32'hFFFFFFFF, MUL_LAT, 1'b0, a0);
    run_op("mulhsu_m1_2", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd11, 32'hFFFFFFFF, MUL_LAT, 1'b0, a0);
    run_op("mulhsu_2_u",  3'b010, 32'd2,        32'hFFFFFFFF, 5'd12, 32'h00000001, MUL_LAT, 1'b0, a0);

    // Divide family, DIVU then REMU back-to-back
    run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 5'd4, 32'd14, DIV_LAT, 1'b1, a0);
    run_op("remu_100_7",  3'b111, 32'd100, 32'd7, 5'd5, 32'd2,  DIV_LAT, 1'b0, a1);
    check_val("b2b.accept_gap", a1 - a0, W + 2);
    run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, DIV_LAT, 1'b0, a0);
    run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, DIV_LAT, 1'b0, a0);
    run_op("divu_big_2",  3'b101, 32'hFFFFFFF9, 32'd2,        5'd15, 32'h7FFFFFFC, DIV_LAT, 1'b0, a0);
    run_op("divu_min_m1", 3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, DIV_LAT, 1'b0, a0);

    // Divide special cases
    run_op("div_5_0",     3'b100, 32'd5,        32'd0,        5'd6,  32'hFFFFFFFF, 1, 1'b0, a0);
    run_op("rem_5_0",     3'b110, 32'd5,        32'd0,        5'd7,  32'd5,        1, 1'b0, a0);
    run_op("remu_9_0",    3'b111, 32'd9,        32'd0,        5'd17, 32'd9,        1, 1'b0, a0);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1, 1'b0, a0);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1, 1'b0, a0);

    // Flush in cycle 10 of a divide
    pulses = 0;
    @(posedge CLK); #1;
    start_EX = 1'b1; funct3_EX = 3'b101; read_data1_EX = 32'd100; read_data2_EX = 32'd7; wrin_EX = 5'd20;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (c == 10) begin flush = 1'b1; start_EX = 1'b0; end
      @(negedge CLK);
      if (result_valid) pulses++;
      if (c == 10) check_val("flush.stall_c10", {31'd0, stall}, 32'd1);
    end
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    check_val("flush.stall_c11", {31'd0, stall}, 32'd0);
    check_val("flush.busy_c11", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (result_valid) pulses++;
    end
    check_val("flush.no_valid", pulses, 0);
    run_op("after_flush", 3'b111, 32'd23, 32'd5, 5'd21, 32'd3, DIV_LAT, 1'b0, a0);

    // Reset in cycle 10 of a long operation
    pulses = 0;
    @(posedge CLK); #1;
    start_EX = 1'b1; read_data1_EX = 32'd7; read_data2_EX = 32'd3; wrin_EX = 5'd22;
`ifdef MULDIV_FAST_MUL_EN
    funct3_EX = 3'b101;
`else
    funct3_EX = 3'b000;
`endif
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (result_valid) pulses++;
    end
    check_val("rstmid.busy_c9", {31'd0, busy}, 32'd1);
    @(posedge CLK); #1;
    RESET_N = 1'b0; start_EX = 1'b0;
    #1;
    check_val("rstmid.busy", {31'd0, busy}, 32'd0);
    check_val("rstmid.stall", {31'd0, stall}, 32'd0);
    check_val("rstmid.result", result, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (result_valid) pulses++;
    end
    check_val("rstmid.no_valid", pulses, 0);
    run_op("after_reset", 3'b000, 32'd6, 32'd7, 5'd23, 32'd42, MUL_LAT, 1'b0, a0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: size, default 32, operand/result width.
REQ-002 CLK  input  1  single clock, rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 start_EX  input  1  EX-stage instruction is an M-extension op, held stable by the ID/EX register while stall is high.
REQ-005 funct3_EX  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 read_data1_EX  input  size  rs1 operand.
REQ-007 read_data2_EX  input  size  rs2 operand.
REQ-008 wrin_EX  input  5  destination register index.
REQ-009 flush  input  1  abort the in-flight op.
REQ-010 stall  output  1  freeze PC, IF/ID and ID/EX.
REQ-011 busy  output  1  state is MUL or DIV.
REQ-012 result  output  size  op result, valid when result_valid is 1.
REQ-013 result_valid  output  1  one-cycle completion pulse.
REQ-014 wrin_out  output  5  destination index captured at accept.

Function
REQ-015 FSM states: IDLE, MUL, DIV, DONE.
REQ-016 Accept occurs only in IDLE with start_EX=1 and flush=0; operands, funct3 and wrin_EX are latched at accept; start_EX outside IDLE is ignored.
REQ-017 Transition on accept: funct3[2]=0 goes to MUL; funct3[2]=1 goes to DIV, except special cases (REQ-022/023) which go to DONE.
REQ-018 MUL/DIV run exactly size iterations on a down-counter of clog2(size)+1 bits, then go to DONE; DONE always goes to IDLE next cycle.
REQ-019 stall = (IDLE & start_EX & !flush) | MUL | DIV; stall is low in DONE so the pipeline advances at the end of the DONE cycle.
REQ-020 Latency: accept in cycle 0; result_valid=1 only in cycle size+1, with 33 stall cycles at size=32; the next op can be accepted in cycle size+2.
REQ-021 Arithmetic:
- iterative shift-add multiply on magnitudes to a 2*size product, sign fixed at the end;
- MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed*signed, signed*unsigned and unsigned*unsigned operands;
- restoring divide on magnitudes;
- quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-022 Divide by zero: quotient all ones, remainder rs1; state goes directly to DONE (result_valid in cycle 1).
REQ-023 Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM): quotient rs1, remainder 0; state goes directly to DONE.
REQ-024 flush in any state: next state IDLE, result_valid stays 0, stall low from the next cycle; flush has priority over DONE output.
REQ-025 result and wrin_out hold their last value outside DONE.

Reset
REQ-026 RESET_N low asynchronously forces IDLE and zeros the counter, operand registers, result, wrin_out, result_valid and busy; stall then follows REQ-019.
REQ-027 Reset mid-operation discards the op with no result_valid pulse.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN defined: multiply ops use a single-cycle combinational product, IDLE goes to DONE, result_valid in cycle 1, 1 stall cycle; MUL state is unused.
REQ-029 Macro MULDIV_FAST_MUL_EN undefined: iterative multiply per REQ-018/020; divide behaviour is identical in both builds.

Structure
REQ-030 Shared package muldiv_pkg: funct3 op enum, FSM state enum, MULDIV_ITER constant (= size).
REQ-031 One sub-module div_step: combinational restoring-divide iteration (partial remainder, quotient bit), instantiated once.

Verification
REQ-032 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, result_valid in cycle 33, stall high cycles 0-32.
REQ-033 DIVU 100/7 -> 14 and REMU 100/7 -> 2, issued back-to-back -> second accept in cycle 34.
REQ-034 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, result_valid in cycle 1.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 flush in cycle 10 of DIV -> stall low in cycle 11, no result_valid; RESET_N low in cycle 10 of MUL -> IDLE immediately, no result_valid.
REQ-037 Build with MULDIV_FAST_MUL_EN: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000, result_valid in cycle 1.
